// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, waits for synchronized lock, retries on timeout, releases sys_rst after stable lock.
// Latency: ready rises SYNC_STAGES+STABLE_CYCLES+1 cycles after lock is first sampled; sys_rst reasserts SYNC_STAGES+1 cycles after loss.
// Backpressure: none; free-running control block with Moore outputs decoded from registered state. Optional LOCK_LOSS_CNT_EN builds lock_loss_cnt.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  // Terminal values of the shared phase counter, one per timed state.
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Three-bit encoding leaves spare codes; any of them falls back to PLL_RESET.
  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   retry_inc;
`ifdef LOCK_LOSS_CNT_EN
  logic                   loss_inc;
  logic [7:0]             loss_q;
`endif

  // Bring the asynchronous locked flag into refclk through a plain flop chain.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // State and phase counter register; rst forces a fresh PLL reset pulse.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= S_PLL_RESET;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter restarts from zero on every state change.
  always_comb begin
    state_nxt = S_PLL_RESET;
    cnt_nxt   = '0;
    retry_inc = 1'b0;
`ifdef LOCK_LOSS_CNT_EN
    loss_inc  = 1'b0;
`endif
    case (state)
      S_PLL_RESET: begin
        if (cnt == RST_LAST) begin
          state_nxt = S_WAIT_LOCK;
        end else begin
          state_nxt = S_PLL_RESET;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = S_STABILIZE;
        end else if (cnt == TMO_LAST) begin
          state_nxt = S_PLL_RESET;
          retry_inc = 1'b1;
        end else begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      S_STABILIZE: begin
        // Any dropout sends us back to waiting with a fresh timeout window.
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
        end else if (cnt == STB_LAST) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_STABILIZE;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
`ifdef LOCK_LOSS_CNT_EN
          loss_inc  = 1'b1;
`endif
        end else begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_PLL_RESET;
      end
    endcase
  end

  // Moore output decode; unknown codes look like PLL_RESET.
  always_comb begin
    pll_rst = 1'b1;
    sys_rst = 1'b1;
    ready   = 1'b0;
    case (state)
      S_WAIT_LOCK: pll_rst = 1'b0;
      S_STABILIZE: pll_rst = 1'b0;
      S_RUN: begin
        pll_rst = 1'b0;
        sys_rst = 1'b0;
        ready   = 1'b1;
      end
      default: ;
    endcase
  end

  // Saturating count of timeout-driven PLL re-resets; retries continue past 15.
  always_ff @(posedge refclk) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (retry_inc && (retry_cnt != 4'd15)) begin
      retry_cnt <= retry_cnt + 4'd1;
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  // Saturating count of RUN to WAIT_LOCK drops; only rst clears it.
  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_q <= '0;
    end else if (loss_inc && (loss_q != 8'd255)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor with short timing parameters (sync 2, reset 4, timeout 20, stable 8).
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Latencies are counted with the sampling edge as cycle 1, so "11 cycles" means the 11th edge.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int checks   = 0;
  int failures = 0;

`ifdef LOCK_LOSS_CNT_EN
  localparam int LL = 1;
`else
  localparam int LL = 0;
`endif

  pll_lock_supervisor #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .CNT_W         (16)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic rst;
    logic lk;
    int   n;
    logic p;
    logic s;
    logic r;
    int   retry;
    int   loss;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst_i, logic lk_i, int n_i, logic p_i, logic s_i,
                              logic r_i, int retry_i, int loss_i);
    vec_t v;
    v.rst   = rst_i;
    v.lk    = lk_i;
    v.n     = n_i;
    v.p     = p_i;
    v.s     = s_i;
    v.r     = r_i;
    v.retry = retry_i;
    v.loss  = loss_i;
    return v;
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check1(string tag, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_out(string tag, logic p, logic s, logic r, int retry, int loss);
    check1({tag, ".pll_rst"}, int'(pll_rst), int'(p));
    check1({tag, ".sys_rst"}, int'(sys_rst), int'(s));
    check1({tag, ".ready"}, int'(ready), int'(r));
    check1({tag, ".retry_cnt"}, int'(retry_cnt), retry);
    check1({tag, ".lock_loss_cnt"}, int'(lock_loss_cnt), loss);
  endtask

  // Hard stop in case something upstream stalls the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within 200000 time units");
    $fatal(1);
  end

  int er;

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;

    // Scenario 1: reset 3 cycles, release, lock first sampled at edge 10, ready at edge 20.
    tbl.push_back(mk(1, 0,  3, 1, 1, 0, 0, 0));   // held in reset
    tbl.push_back(mk(0, 0,  3, 1, 1, 0, 0, 0));   // PLL_RESET cnt 1..3 (4 cycles incl. last rst edge)
    tbl.push_back(mk(0, 0,  3, 0, 1, 0, 0, 0));   // WAIT_LOCK cnt 0..2
    tbl.push_back(mk(0, 1, 10, 0, 1, 0, 0, 0));   // lock sampled, sync + stabilize
    tbl.push_back(mk(0, 1,  5, 0, 0, 1, 0, 0));   // RUN from the 11th edge
    // Scenario 4: drop lock in RUN, sys_rst back on the 3rd edge, then relock.
    tbl.push_back(mk(0, 0,  2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0,  1, 0, 1, 0, 0, LL));
    tbl.push_back(mk(0, 1, 10, 0, 1, 0, 0, LL));
    tbl.push_back(mk(0, 1,  3, 0, 0, 1, 0, LL));
    // Reset out of RUN clears everything; then scenario 3 glitch (5 high, 2 low, high).
    tbl.push_back(mk(1, 0,  1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,  3, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,  3, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1,  5, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,  2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 10, 0, 1, 0, 0, 0));   // no release from the short first pulse
    tbl.push_back(mk(0, 1,  2, 0, 0, 1, 0, 0));   // ready 11 cycles after the second rise
    // Scenario 2 lead-in: reset, PLL_RESET, first 20-cycle wait without lock.
    tbl.push_back(mk(1, 0,  1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,  3, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 20, 0, 1, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst        = tbl[i].rst;
      pll_locked = tbl[i].lk;
      for (int c = 0; c < tbl[i].n; c++) begin
        tick();
        check_out($sformatf("row%0d_cyc%0d", i, c), tbl[i].p, tbl[i].s, tbl[i].r,
                  tbl[i].retry, tbl[i].loss);
      end
    end

    // Scenario 2: never-locking PLL, 4-high/20-low pll_rst period, retry_cnt saturates at 15.
    for (int k = 1; k <= 17; k++) begin
      er = (k > 15) ? 15 : k;
      for (int c = 0; c < 4; c++) begin
        tick();
        check_out($sformatf("retry%0d_rst%0d", k, c), 1, 1, 0, er, 0);
      end
      for (int c = 0; c < 20; c++) begin
        tick();
        check_out($sformatf("retry%0d_wait%0d", k, c), 0, 1, 0, er, 0);
      end
    end

    // Lock after saturation: reaches RUN, retry_cnt keeps its value.
    pll_locked = 1'b1;
    for (int c = 0; c < 30; c++) tick();
    check_out("late_lock_run", 0, 0, 1, 15, 0);

    // Drop lock for 3 cycles: still RUN after 2 edges, back in WAIT_LOCK on the 3rd.
    pll_locked = 1'b0;
    tick();
    check_out("drop2_c0", 0, 0, 1, 15, 0);
    tick();
    check_out("drop2_c1", 0, 0, 1, 15, 0);
    tick();
    check_out("drop2_c2", 0, 1, 0, 15, LL);

    // Relock into STABILIZE, then pulse rst in the middle of it (scenario 5).
    pll_locked = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_out($sformatf("restab_c%0d", c), 0, 1, 0, 15, LL);
    end
    rst = 1'b1;
    tick();
    check_out("rst_mid_stab", 1, 1, 0, 0, 0);

    // Release with lock already held: sync refills, RUN on the 13th edge after release.
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check1($sformatf("post_rst_c%0d.ready", c), int'(ready), 0);
    end
    tick();
    check_out("post_rst_run", 0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
